// File: rtl/mips_pkg.sv
// Shared defaults for the MIPS decode-stage register bank and the helper that
// locates a read port's field inside a packed multi-port bus.
package mips_pkg;

   localparam int DATA_W_PADRAO = 32;
   localparam int ADDR_W_PADRAO = 5;
   localparam int REG_ZERO      = 0;

   // LSB position of port `porta` in a bus packing fields of `largura` bits
   function automatic int campo_lsb(input int porta, input int largura);
      return porta * largura;
   endfunction

endpackage

// File: rtl/placar_registradores.sv
// Scoreboard of pending destination registers: mark on issue, clear on write-back,
// with a saturating up/down count of pending entries.
module placar_registradores
   import mips_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_PADRAO,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   marca_i,
   input  logic [ADDR_W-1:0]      destino_i,
   input  logic                   limpa_i,
   input  logic [ADDR_W-1:0]      escrita_i,
   output logic [(1<<ADDR_W)-1:0] pendente_o,
   output logic [ADDR_W:0]        contagem_o
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] LIMITE = ZERO_REG ? (ADDR_W+1)'(DEPTH-1) : (ADDR_W+1)'(DEPTH);

   logic [DEPTH-1:0] pendente_q, pendente_d;
   logic [ADDR_W:0]  contagem_q, contagem_d;
   logic             marca_ef, limpa_ef, sobe, desce;

   always_comb begin
      marca_ef   = marca_i && !(ZERO_REG && (destino_i == ADDR_W'(REG_ZERO)));
      limpa_ef   = limpa_i && !(ZERO_REG && (escrita_i == ADDR_W'(REG_ZERO)));
      pendente_d = pendente_q;
      // Clear first so a same-address mark (newer producer) wins
      if (limpa_ef) pendente_d[escrita_i] = 1'b0;
      if (marca_ef) pendente_d[destino_i] = 1'b1;

      sobe  = marca_ef && !pendente_q[destino_i];
      desce = limpa_ef && pendente_q[escrita_i] && !(marca_ef && (destino_i == escrita_i));

      contagem_d = contagem_q;
      if (sobe && !desce && (contagem_q != LIMITE))
         contagem_d = contagem_q + 1'b1;
      else if (desce && !sobe && (contagem_q != '0))
         contagem_d = contagem_q - 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pendente_q <= '0;
         contagem_q <= '0;
      end else begin
         pendente_q <= pendente_d;
         contagem_q <= contagem_d;
      end
   end

   assign pendente_o = pendente_q;
   assign contagem_o = contagem_q;

endmodule

// File: rtl/banco_registradores_param.sv
// Parametrised multi-read-port register file with optional zero register, write-back
// bypass and per-port hazard flags from the integrated scoreboard.
module banco_registradores_param
   import mips_pkg::*;
#(
   parameter int DATA_W   = DATA_W_PADRAO,
   parameter int ADDR_W   = ADDR_W_PADRAO,
   parameter int N_READ   = 2,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic                       Clock,
   input  logic                       Reset_n,
   input  logic                       Reg_Write,
   input  logic [ADDR_W-1:0]          Reg_escrita,
   input  logic [DATA_W-1:0]          Reg_dados,
   input  logic                       Marca,
   input  logic [ADDR_W-1:0]          Reg_destino,
   input  logic [N_READ*ADDR_W-1:0]   Reg_leitura,
   output logic [N_READ*DATA_W-1:0]   Dados_leitura,
   output logic [N_READ-1:0]          Perigo,
   output logic [ADDR_W:0]            Pendentes
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]  pendente;
   logic              escreve;

   assign escreve = Reg_Write && !(ZERO_REG && (Reg_escrita == ADDR_W'(REG_ZERO)));

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (escreve) begin
         mem_q[Reg_escrita] <= Reg_dados;
      end
   end

   placar_registradores #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_placar (
      .clk_i      (Clock),
      .rst_ni     (Reset_n),
      .marca_i    (Marca),
      .destino_i  (Reg_destino),
      .limpa_i    (Reg_Write),
      .escrita_i  (Reg_escrita),
      .pendente_o (pendente),
      .contagem_o (Pendentes)
   );

   for (genvar k = 0; k < N_READ; k++) begin : g_leitura
      logic [ADDR_W-1:0] end_k;
      logic [DATA_W-1:0] dado_k;
      logic              perigo_k, eh_zero, desvio;

      always_comb begin
         end_k    = Reg_leitura[campo_lsb(k, ADDR_W) +: ADDR_W];
         eh_zero  = ZERO_REG && (end_k == ADDR_W'(REG_ZERO));
         desvio   = BYPASS && escreve && (Reg_escrita == end_k);
         dado_k   = mem_q[end_k];
         perigo_k = pendente[end_k];
         // Reset forces quiet outputs even with live write-back inputs
         if (!Reset_n || eh_zero) begin
            dado_k   = '0;
            perigo_k = 1'b0;
         end else if (desvio) begin
            dado_k   = Reg_dados;
            perigo_k = 1'b0;
         end
      end

      assign Dados_leitura[campo_lsb(k, DATA_W) +: DATA_W] = dado_k;
      assign Perigo[k] = perigo_k;
   end

endmodule

// File: tb/tb_banco_registradores_param.sv
// Directed-vector bench: default instance (32x32, 2 ports, zero reg, bypass) and a
// small 16x8, 3-port instance without zero register or bypass.
module tb_banco_registradores_param;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        wr0, mk0;
   logic [4:0]  wa0, md0;
   logic [31:0] wd0;
   logic [9:0]  ra0;
   logic [63:0] rd0;
   logic [1:0]  pg0;
   logic [5:0]  pc0;

   logic        wr1, mk1;
   logic [2:0]  wa1, md1;
   logic [15:0] wd1;
   logic [8:0]  ra1;
   logic [47:0] rd1;
   logic [2:0]  pg1;
   logic [3:0]  pc1;

   int n_cmp = 0;
   int n_err = 0;

   banco_registradores_param u0 (
      .Clock(clk), .Reset_n(rst_n), .Reg_Write(wr0), .Reg_escrita(wa0), .Reg_dados(wd0),
      .Marca(mk0), .Reg_destino(md0), .Reg_leitura(ra0), .Dados_leitura(rd0),
      .Perigo(pg0), .Pendentes(pc0)
   );

   banco_registradores_param #(
      .DATA_W(16), .ADDR_W(3), .N_READ(3), .ZERO_REG(1'b0), .BYPASS(1'b0)
   ) u1 (
      .Clock(clk), .Reset_n(rst_n), .Reg_Write(wr1), .Reg_escrita(wa1), .Reg_dados(wd1),
      .Marca(mk1), .Reg_destino(md1), .Reg_leitura(ra1), .Dados_leitura(rd1),
      .Perigo(pg1), .Pendentes(pc1)
   );

   task automatic passo();
      @(posedge clk);
      #1;
   endtask

   task automatic ocioso();
      wr0 = 1'b0; mk0 = 1'b0; wa0 = '0; md0 = '0; wd0 = '0;
      wr1 = 1'b0; mk1 = 1'b0; wa1 = '0; md1 = '0; wd1 = '0;
   endtask

   task automatic test_reset();
      ocioso();
      ra0 = {5'd5, 5'd5};
      ra1 = '0;
      #1;
      n_cmp++; if (rd0 !== 64'h0) begin n_err++; $display("FAIL reset_data got %h want 0", rd0); end
      n_cmp++; if (pc0 !== 6'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", pc0); end
      n_cmp++; if (pg0 !== 2'b00) begin n_err++; $display("FAIL reset_hazard got %b want 00", pg0); end
      @(negedge clk) rst_n = 1'b1;
      passo();
      wr0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; mk0 = 1'b1; md0 = 5'd5;
      passo();
      ocioso();
      ra0 = {5'd0, 5'd5};
      #1;
      n_cmp++; if (rd0[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL pre_reset_r5 got %h want deadbeef", rd0[31:0]); end
      n_cmp++; if (pc0 !== 6'd1) begin n_err++; $display("FAIL pre_reset_count got %0d want 1", pc0); end
      // Mid-cycle reset with a live bypass write on port 1
      #1;
      rst_n = 1'b0;
      wr0 = 1'b1; wa0 = 5'd5; wd0 = 32'h11111111; ra0 = {5'd5, 5'd5};
      #1;
      n_cmp++; if (rd0 !== 64'h0) begin n_err++; $display("FAIL mid_reset_data got %h want 0", rd0); end
      n_cmp++; if (pc0 !== 6'd0) begin n_err++; $display("FAIL mid_reset_count got %0d want 0", pc0); end
      n_cmp++; if (pg0 !== 2'b00) begin n_err++; $display("FAIL mid_reset_hazard got %b want 00", pg0); end
      ocioso();
      @(negedge clk) rst_n = 1'b1;
      passo();
      n_cmp++; if (rd0 !== 64'h0) begin n_err++; $display("FAIL post_reset_r5 got %h want 0", rd0); end
   endtask

   task automatic test_write_read();
      wr0 = 1'b1; wa0 = 5'd7; wd0 = 32'h12345678;
      passo();
      ocioso();
      ra0 = {5'd7, 5'd7};
      #1;
      n_cmp++; if (rd0 !== {32'h12345678, 32'h12345678}) begin n_err++; $display("FAIL wr_rd_r7 got %h want 1234567812345678", rd0); end
      n_cmp++; if (pg0 !== 2'b00) begin n_err++; $display("FAIL wr_rd_hazard got %b want 00", pg0); end
   endtask

   task automatic test_bypass();
      mk0 = 1'b1; md0 = 5'd9;
      passo();
      ocioso();
      ra0 = {5'd9, 5'd7};
      #1;
      n_cmp++; if (pg0 !== 2'b10) begin n_err++; $display("FAIL byp_marked_hazard got %b want 10", pg0); end
      wr0 = 1'b1; wa0 = 5'd9; wd0 = 32'hCAFEF00D;
      #1;
      n_cmp++; if (rd0[63:32] !== 32'hCAFEF00D) begin n_err++; $display("FAIL byp_data got %h want cafef00d", rd0[63:32]); end
      n_cmp++; if (pg0 !== 2'b00) begin n_err++; $display("FAIL byp_hazard got %b want 00", pg0); end
      passo();
      ocioso();
      #1;
      n_cmp++; if (pc0 !== 6'd0) begin n_err++; $display("FAIL byp_count got %0d want 0", pc0); end
      // No-bypass instance returns the old array value in the write cycle
      ra1 = {3'd0, 3'd5, 3'd0};
      wr1 = 1'b1; wa1 = 3'd5; wd1 = 16'hBEEF;
      #1;
      n_cmp++; if (rd1[31:16] !== 16'h0000) begin n_err++; $display("FAIL nobyp_same_cycle got %h want 0000", rd1[31:16]); end
      passo();
      ocioso();
      #1;
      n_cmp++; if (rd1[31:16] !== 16'hBEEF) begin n_err++; $display("FAIL nobyp_next_cycle got %h want beef", rd1[31:16]); end
   endtask

   task automatic test_zero();
      wr0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; mk0 = 1'b1; md0 = 5'd0;
      ra0 = {5'd7, 5'd0};
      #1;
      n_cmp++; if (rd0[31:0] !== 32'h0) begin n_err++; $display("FAIL zero_no_bypass got %h want 0", rd0[31:0]); end
      passo();
      ocioso();
      #1;
      n_cmp++; if (rd0[31:0] !== 32'h0) begin n_err++; $display("FAIL zero_read got %h want 0", rd0[31:0]); end
      n_cmp++; if (pg0[0] !== 1'b0) begin n_err++; $display("FAIL zero_hazard got %b want 0", pg0[0]); end
      n_cmp++; if (pc0 !== 6'd0) begin n_err++; $display("FAIL zero_count got %0d want 0", pc0); end
   endtask

   task automatic test_scoreboard();
      mk0 = 1'b1; md0 = 5'd3;
      passo();
      md0 = 5'd4;
      passo();
      ocioso();
      ra0 = {5'd4, 5'd3};
      #1;
      n_cmp++; if (pc0 !== 6'd2) begin n_err++; $display("FAIL sb_two_marked got %0d want 2", pc0); end
      n_cmp++; if (pg0 !== 2'b11) begin n_err++; $display("FAIL sb_hazards got %b want 11", pg0); end
      wr0 = 1'b1; wa0 = 5'd3; wd0 = 32'h33;
      passo();
      ocioso();
      #1;
      n_cmp++; if (pc0 !== 6'd1) begin n_err++; $display("FAIL sb_wb_r3 got %0d want 1", pc0); end
      n_cmp++; if (pg0 !== 2'b10) begin n_err++; $display("FAIL sb_wb_hazard got %b want 10", pg0); end
      mk0 = 1'b1; md0 = 5'd4; wr0 = 1'b1; wa0 = 5'd4; wd0 = 32'h44;
      passo();
      ocioso();
      ra0 = {5'd4, 5'd3};
      #1;
      n_cmp++; if (pc0 !== 6'd1) begin n_err++; $display("FAIL sb_mark_wins_count got %0d want 1", pc0); end
      n_cmp++; if (pg0 !== 2'b10) begin n_err++; $display("FAIL sb_mark_wins_hazard got %b want 10", pg0); end
      n_cmp++; if (rd0 !== {32'h44, 32'h33}) begin n_err++; $display("FAIL sb_array_written got %h want 0000004400000033", rd0); end
      // Mark one register while retiring another: count unchanged
      mk0 = 1'b1; md0 = 5'd10; wr0 = 1'b1; wa0 = 5'd4; wd0 = 32'h45;
      passo();
      ocioso();
      #1;
      n_cmp++; if (pc0 !== 6'd1) begin n_err++; $display("FAIL sb_mark_clear_diff got %0d want 1", pc0); end
      wr0 = 1'b1; wa0 = 5'd10; wd0 = 32'h0;
      passo();
      ocioso();
      #1;
      n_cmp++; if (pc0 !== 6'd0) begin n_err++; $display("FAIL sb_drain got %0d want 0", pc0); end
   endtask

   task automatic test_sweep();
      wr1 = 1'b1; wa1 = 3'd7; wd1 = 16'h1234;
      passo();
      ocioso();
      ra1 = {3'd7, 3'd7, 3'd7};
      #1;
      n_cmp++; if (rd1 !== {16'h1234, 16'h1234, 16'h1234}) begin n_err++; $display("FAIL sw_rd_r7 got %h want 123412341234", rd1); end
      n_cmp++; if (pg1 !== 3'b000) begin n_err++; $display("FAIL sw_rd_hazard got %b want 000", pg1); end
      wr1 = 1'b1; wa1 = 3'd0; wd1 = 16'h00AA;
      passo();
      ocioso();
      ra1 = {3'd7, 3'd5, 3'd0};
      #1;
      n_cmp++; if (rd1 !== {16'h1234, 16'hBEEF, 16'h00AA}) begin n_err++; $display("FAIL sw_r0_writable got %h want 1234beef00aa", rd1); end
      for (int i = 0; i < 8; i++) begin
         mk1 = 1'b1; md1 = 3'(i);
         passo();
      end
      ocioso();
      ra1 = {3'd0, 3'd7, 3'd3};
      #1;
      n_cmp++; if (pc1 !== 4'd8) begin n_err++; $display("FAIL sw_all_marked got %0d want 8", pc1); end
      n_cmp++; if (pg1 !== 3'b111) begin n_err++; $display("FAIL sw_all_hazard got %b want 111", pg1); end
      wr1 = 1'b1; wa1 = 3'd7; wd1 = 16'h7777;
      passo();
      ocioso();
      #1;
      n_cmp++; if (pc1 !== 4'd7) begin n_err++; $display("FAIL sw_wb_r7 got %0d want 7", pc1); end
      n_cmp++; if (pg1 !== 3'b101) begin n_err++; $display("FAIL sw_wb_hazard got %b want 101", pg1); end
      mk1 = 1'b1; md1 = 3'd7; wr1 = 1'b1; wa1 = 3'd7; wd1 = 16'h7070;
      passo();
      ocioso();
      #1;
      n_cmp++; if (pc1 !== 4'd8) begin n_err++; $display("FAIL sw_remark_r7 got %0d want 8", pc1); end
      n_cmp++; if (rd1[31:16] !== 16'h7070) begin n_err++; $display("FAIL sw_r7_data got %h want 7070", rd1[31:16]); end
      n_cmp++; if (pg1 !== 3'b111) begin n_err++; $display("FAIL sw_remark_hazard got %b want 111", pg1); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_zero();
      test_scoreboard();
      test_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/banco_registradores_param.md
# banco_registradores_param

Parametrised successor to the single-cycle MIPS register file: a configurable-width, configurable-depth, multi-read-port register bank with asynchronous active-low reset, optional hardwired zero register, optional write-to-read bypass, and an integrated scoreboard of pending destination registers. It sits in the decode stage of the pipelined datapath. It feeds operand values and per-port hazard flags to the hazard/stall unit and accepts write-back from the WB stage.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- N_READ, 2, number of combinational read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/marks
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
- Clock  in  1  single clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Reg_Write  in  1  write-back enable
- Reg_escrita  in  ADDR_W  write-back address
- Reg_dados  in  DATA_W  write-back data
- Marca  in  1  issue strobe: mark Reg_destino as pending
- Reg_destino  in  ADDR_W  destination being issued
- Reg_leitura  in  N_READ*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- Dados_leitura  out  N_READ*DATA_W  read data, same packing
- Perigo  out  N_READ  per-port hazard: operand not yet available
- Pendentes  out  ADDR_W+1  count of pending registers

## Operation
- Storage: 2**ADDR_W × DATA_W array plus a 2**ADDR_W-bit pending vector.
- Write: on rising Clock with Reg_Write=1, array[Reg_escrita] <= Reg_dados. The write also clears pending[Reg_escrita].
- Mark: on rising Clock with Marca=1, pending[Reg_destino] <= 1.
- Mark and clear hit the same address in the same cycle: mark wins and the bit ends at 1, because a newer producer has been issued. The array is still written.
- ZERO_REG=1: writes and marks to address 0 are ignored, and reads of address 0 return 0 with Perigo=0.
- Read port k is combinational from Reg_leitura[k], the array, and the write-back inputs.
- BYPASS=1 and Reg_Write=1 and Reg_escrita==addr_k (and addr_k≠0 when ZERO_REG): data_k = Reg_dados and Perigo[k]=0.
- Otherwise: data_k = array[addr_k] and Perigo[k] = pending[addr_k].
- BYPASS=0: reads always come from the array, and Perigo ignores the same-cycle write.
- Pendentes equals popcount(pending) at all times. Implement it as an up/down counter: +1 on an effective mark of a non-pending bit, −1 on an effective clear of a pending bit, net 0 when both occur. Cap it at 2**ADDR_W (or 2**ADDR_W−1 with ZERO_REG).

## Timing
- Reset_n low, asynchronously: every array entry = 0, pending = 0, Pendentes = 0.
- While Reset_n is low, Dados_leitura = 0 and Perigo = 0 regardless of inputs; bypass is suppressed.
- First write is accepted on the first rising edge after Reset_n is sampled high.
- Reset asserted mid-operation discards all pending marks and register contents immediately; there is no deferred write.
- Write latency: 1 edge to the array, 0 cycles to a bypassed read.
- Mark latency: Perigo rises the cycle after the Marca edge.
- Reads have no latency beyond combinational delay.

## Structure
- Shared package `mips_pkg`: default DATA_W/ADDR_W constants, the zero-register address constant, and the read-port pack/unpack helper function.
- One sub-module is natural: `placar_registradores`, which holds the pending vector, mark/clear arbitration and the Pendentes counter. The top level holds the array, read muxes and bypass.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert Reset_n=0 mid-cycle -> Dados_leitura for r5 = 0 immediately, Pendentes = 0.
- Write/read: write 0x12345678 to r7, then read r7 on ports 0 and 1 next cycle -> both 0x12345678, Perigo = 00.
- Bypass: Reg_Write=1, r9 ← 0xCAFEF00D while port 1 reads r9 in the same cycle -> port 1 = 0xCAFEF00D (BYPASS=1) or old value 0 (BYPASS=0).
- Zero register: write 0xFFFFFFFF to r0 and Marca r0 -> read r0 = 0, Perigo = 0, Pendentes unchanged.
- Scoreboard: mark r3 and r4 -> Pendentes = 2 and Perigo set on a port reading r3. Write-back r3 -> Pendentes = 1. Same-cycle mark+write r4 -> r4 stays pending, Pendentes = 1.
- Parameter sweep: DATA_W=16, ADDR_W=3, N_READ=3 -> repeat the write/read and scoreboard cases at 8 entries, including address 7 wrap.
